// File: rtl/mips_rf_pkg.sv
// Shared types and helpers for the MIPS register file with busy scoreboard.
// Imported by the top module and the scoreboard sub-module.
package mips_rf_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam int DEF_W     = 32;
    localparam int DEF_NREGS = 32;

    // Low bit of the field belonging to a given port in a flattened port bus.
    function automatic int unsigned slice_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/mips_rf_scoreboard.sv
// Per-register busy bits for hazard detection, with NRD combinational lookup ports.
// Priority per edge: reset, then flush, then issue (set) over writeback (clear).
module mips_rf_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] lookup_addr,
    output logic [NRD-1:0]    lookup_busy
);

    logic [NREGS-1:0] busy;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            // Issued after the clear so a new producer on the same register wins.
            if (set_en) busy[set_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_lookup
        assign lookup_busy[k] = busy[lookup_addr[slice_lsb(k, AW) +: AW]];
    end

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS register file: NRD async read ports with write bypass, one sync write port,
// busy scoreboard, and a post-reset sweep that zeroes every entry before RUN.
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr_in,
    output logic [NRD*W-1:0]  rd_data_out,
    output logic [NRD-1:0]    rd_busy_out,
    input  logic              wr_en_in,
    input  logic [AW-1:0]     wr_addr_in,
    input  logic [W-1:0]      wr_data_in,
    input  logic              iss_en_in,
    input  logic [AW-1:0]     iss_addr_in,
    input  logic              flush_in,
    output logic              ready_out
);

    state_t        state;
    logic [AW-1:0] sweep_cnt;
    logic [W-1:0]  mem [NREGS];
    logic [NRD-1:0] sb_busy;
    logic          run;
    logic          wr_live;

    assign run     = (state == RUN);
    assign wr_live = run && wr_en_in && (wr_addr_in != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            ready_out <= 1'b0;
        end else if (state == CLEAR) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == AW'(NREGS - 1)) begin
                state     <= RUN;
                ready_out <= 1'b1;
            end
        end
    end

    // NOTE: the array has no reset term so it maps onto RAM; the sweep zeroes it instead.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR)
                mem[sweep_cnt] <= '0;
            else if (wr_live)
                mem[wr_addr_in] <= wr_data_in;
        end
    end

    mips_rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .set_en      (run && iss_en_in && (iss_addr_in != '0)),
        .set_addr    (iss_addr_in),
        .clr_en      (wr_live),
        .clr_addr    (wr_addr_in),
        .flush       (run && flush_in),
        .lookup_addr (rd_addr_in),
        .lookup_busy (sb_busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic          busy;

        assign addr = rd_addr_in[slice_lsb(k, AW) +: AW];

        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        always_comb begin
            data = '0;
            busy = 1'b0;
            if (run && addr != '0) begin
                if (wr_en_in && wr_addr_in == addr) begin
                    data = wr_data_in;
                end else begin
                    data = mem[addr];
                    busy = sb_busy[k];
                end
            end
        end

        assign rd_data_out[slice_lsb(k, W) +: W] = data;
        assign rd_busy_out[k]                    = busy;
    end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Scoreboard bench for mips_regfile_sb (W=32, NREGS=16, NRD=3): a driver pushes the
// model's expected outputs per cycle, a monitor pops and compares at the falling edge.
module tb_mips_regfile_sb;

    localparam int W     = 32;
    localparam int NREGS = 16;
    localparam int NRD   = 3;
    localparam int AW    = $clog2(NREGS);

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NRD*AW-1:0] rd_addr_in = '0;
    logic [NRD*W-1:0]  rd_data_out;
    logic [NRD-1:0]    rd_busy_out;
    logic              wr_en_in = 1'b0;
    logic [AW-1:0]     wr_addr_in = '0;
    logic [W-1:0]      wr_data_in = '0;
    logic              iss_en_in = 1'b0;
    logic [AW-1:0]     iss_addr_in = '0;
    logic              flush_in = 1'b0;
    logic              ready_out;

    mips_regfile_sb #(.W(W), .NREGS(NREGS), .NRD(NRD)) dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr_in  (rd_addr_in),
        .rd_data_out (rd_data_out),
        .rd_busy_out (rd_busy_out),
        .wr_en_in    (wr_en_in),
        .wr_addr_in  (wr_addr_in),
        .wr_data_in  (wr_data_in),
        .iss_en_in   (iss_en_in),
        .iss_addr_in (iss_addr_in),
        .flush_in    (flush_in),
        .ready_out   (ready_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] data [NRD];
        logic         busy [NRD];
        logic         ready;
    } exp_t;

    exp_t q[$];

    // Reference model: architectural view of the register file.
    logic [W-1:0] ref_mem  [NREGS];
    logic         ref_busy [NREGS];
    logic         ref_ready = 1'b0;
    int           low_edges = 0;
    logic         model_init = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the expected pre-edge outputs are queued first.
    task automatic step(input logic rst, input int a0, input int a1, input int a2,
                        input logic we, input int wa, input logic [W-1:0] wd,
                        input logic ie, input int ia, input logic fl);
        int   addrs [NRD];
        exp_t e;
        addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
        reset       = rst;
        rd_addr_in  = {AW'(a2), AW'(a1), AW'(a0)};
        wr_en_in    = we;
        wr_addr_in  = AW'(wa);
        wr_data_in  = wd;
        iss_en_in   = ie;
        iss_addr_in = AW'(ia);
        flush_in    = fl;

        for (int k = 0; k < NRD; k++) begin
            if (!ref_ready || addrs[k] == 0) begin
                e.data[k] = '0;
                e.busy[k] = 1'b0;
            end else if (we && wa == addrs[k]) begin
                e.data[k] = wd;
                e.busy[k] = 1'b0;
            end else begin
                e.data[k] = ref_mem[addrs[k]];
                e.busy[k] = ref_busy[addrs[k]];
            end
        end
        e.ready = ref_ready;
        if (model_init) q.push_back(e);

        @(posedge clock);
        if (rst) begin
            model_init = 1'b1;
            ref_ready  = 1'b0;
            low_edges  = 0;
            for (int r = 0; r < NREGS; r++) begin
                ref_mem[r]  = '0;
                ref_busy[r] = 1'b0;
            end
        end else if (!ref_ready) begin
            low_edges++;
            if (low_edges == NREGS) ref_ready = 1'b1;
        end else begin
            if (we && wa != 0) ref_mem[wa] = wd;
            if (fl) begin
                for (int r = 0; r < NREGS; r++) ref_busy[r] = 1'b0;
            end else begin
                if (we && wa != 0) ref_busy[wa] = 1'b0;
                if (ie && ia != 0) ref_busy[ia] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input int a0, input int a1, input int a2);
        for (int i = 0; i < n; i++) step(1'b0, a0, a1, a2, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: every falling edge with a queued expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ready_out", W'(ready_out), W'(e.ready));
                for (int k = 0; k < NRD; k++) begin
                    check($sformatf("rd_data[%0d]", k), rd_data_out[k*W +: W], e.data[k]);
                    check($sformatf("rd_busy[%0d]", k), W'(rd_busy_out[k]), W'(e.busy[k]));
                end
            end
        end
    end

    initial begin
        // Reset for one cycle, then sweep; read and write r5 during the sweep.
        step(1'b1, 5, 5, 5, 1'b0, 0, '0, 1'b0, 0, 1'b0);
        step(1'b0, 5, 0, 1, 1'b1, 5, 32'hAAAA_5555, 1'b1, 6, 1'b0);
        idle(NREGS + 1, 5, 5, 5);

        // Same-cycle bypass on port 1, then array read.
        step(1'b0, 0, 3, 4, 1'b1, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        idle(1, 3, 3, 0);

        // r0 writes and issues are dropped.
        step(1'b0, 0, 0, 0, 1'b1, 0, 32'h1234_5678, 1'b1, 0, 1'b0);
        idle(1, 0, 0, 0);

        // Issue / write interaction on r7.
        step(1'b0, 7, 0, 0, 1'b0, 0, '0, 1'b1, 7, 1'b0);
        idle(1, 7, 7, 7);
        step(1'b0, 7, 7, 0, 1'b1, 7, 32'h55, 1'b1, 7, 1'b0);
        idle(1, 7, 7, 7);
        step(1'b0, 0, 0, 7, 1'b1, 7, 32'h66, 1'b0, 0, 1'b0);
        idle(1, 7, 7, 7);

        // Flush with a same-cycle issue clears everything.
        step(1'b0, 4, 9, 2, 1'b0, 0, '0, 1'b1, 4, 1'b0);
        step(1'b0, 4, 9, 2, 1'b0, 0, '0, 1'b1, 9, 1'b0);
        step(1'b0, 4, 9, 2, 1'b1, 11, 32'hF00D, 1'b1, 2, 1'b1);
        idle(1, 2, 4, 9);
        idle(1, 11, 0, 0);

        // Three ports on distinct slices.
        step(1'b0, 0, 0, 0, 1'b1, 1, 32'h1111_0001, 1'b0, 0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1, 2, 32'h2222_0002, 1'b0, 0, 1'b0);
        step(1'b0, 1, 2, 15, 1'b1, 15, 32'hFFFF_000F, 1'b0, 0, 1'b0);
        idle(1, 1, 2, 15);
        idle(1, 15, 1, 2);

        // Reset mid-sweep at counter 10, then a full sweep.
        step(1'b1, 1, 2, 3, 1'b0, 0, '0, 1'b0, 0, 1'b0);
        idle(10, 1, 2, 3);
        step(1'b1, 1, 2, 3, 1'b1, 1, 32'h77, 1'b1, 1, 1'b0);
        idle(NREGS + 2, 1, 2, 15);

        // Randomized traffic, with occasional flushes and rare resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 199) == 0,
                 int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)),
                 int'($urandom_range(0, NREGS - 1)),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, NREGS - 1)), $urandom,
                 $urandom_range(0, 4) < 2, int'($urandom_range(0, NREGS - 1)),
                 $urandom_range(0, 19) == 0);
        end

        @(negedge clock);
        #1;
        check("queue_drained", W'(q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
